// File: rtl/transfer_timing_if.sv
// Command handshake, transfer window and drum timing strobes between the timing block and its consumers.
// wait_words_o is present only when G15_TR_STATS_EN is defined.
interface transfer_timing_if;
    logic       cmd_valid_i;
    logic [6:0] cmd_l_i;
    logic [6:0] cmd_t_i;
    logic       cmd_immed_i;
    logic       halt_i;
    logic       cmd_ready_o;
    logic       cmd_done_o;
    logic       cmd_err_o;
    logic       tr_o;
    logic       t0_o;
    logic       t28_o;
    logic [4:0] bit_time_o;
    logic [6:0] word_time_o;
    logic [1:0] word_mod4_o;
`ifdef G15_TR_STATS_EN
    logic [6:0] wait_words_o;

    modport master (
        output cmd_valid_i, cmd_l_i, cmd_t_i, cmd_immed_i, halt_i,
        input  cmd_ready_o, cmd_done_o, cmd_err_o, tr_o, t0_o, t28_o,
        input  bit_time_o, word_time_o, word_mod4_o, wait_words_o
    );
    modport slave (
        input  cmd_valid_i, cmd_l_i, cmd_t_i, cmd_immed_i, halt_i,
        output cmd_ready_o, cmd_done_o, cmd_err_o, tr_o, t0_o, t28_o,
        output bit_time_o, word_time_o, word_mod4_o, wait_words_o
    );
`else
    modport master (
        output cmd_valid_i, cmd_l_i, cmd_t_i, cmd_immed_i, halt_i,
        input  cmd_ready_o, cmd_done_o, cmd_err_o, tr_o, t0_o, t28_o,
        input  bit_time_o, word_time_o, word_mod4_o
    );
    modport slave (
        input  cmd_valid_i, cmd_l_i, cmd_t_i, cmd_immed_i, halt_i,
        output cmd_ready_o, cmd_done_o, cmd_err_o, tr_o, t0_o, t28_o,
        output bit_time_o, word_time_o, word_mod4_o
    );
`endif
endinterface

// File: rtl/transfer_timing.sv
// Drum bit/word counters plus command FSM driving the registered TR window, which only moves on word boundaries.
// One command at a time, accepted only while cmd_ready_o (offers otherwise dropped); WAIT_WORDS stats under G15_TR_STATS_EN.
module transfer_timing #(
    parameter int BITS_PER_WORD = 29,
    parameter int WORDS_PER_REV = 108
) (
    input  logic          clk,
    input  logic          rst,
    transfer_timing_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_L, XFER, DONE} state_t;

    localparam logic [4:0] BIT_LAST   = 5'(BITS_PER_WORD - 1);
    localparam logic [6:0] WORD_LAST  = 7'(WORDS_PER_REV - 1);
    localparam logic [6:0] WORD_LIMIT = 7'(WORDS_PER_REV);

    state_t     state_q, state_d;
    logic [4:0] bit_q, bit_d;
    logic [6:0] word_q, word_d;
    logic [6:0] l_q, l_d;
    logic [6:0] t_q, t_d;
    logic       immed_q, immed_d;
    logic       halt_q, halt_d;
    logic       tr_q, tr_d;
    logic       err_q, err_d;
    logic       boundary;
    logic       accept;
    logic [6:0] nxt_word;

    always_comb begin
        boundary = (bit_q == BIT_LAST);
        nxt_word = (word_q == WORD_LAST) ? 7'd0 : word_q + 7'd1;
        bit_d    = boundary ? 5'd0 : bit_q + 5'd1;
        word_d   = boundary ? nxt_word : word_q;
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        t_d     = t_q;
        immed_d = immed_q;
        halt_d  = halt_q;
        tr_d    = tr_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                halt_d = 1'b0;
                if (bus.cmd_valid_i) begin
                    if (bus.cmd_l_i < WORD_LIMIT && bus.cmd_t_i < WORD_LIMIT) begin
                        accept  = 1'b1;
                        l_d     = bus.cmd_l_i;
                        t_d     = bus.cmd_t_i;
                        immed_d = bus.cmd_immed_i;
                        state_d = WAIT_L;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Immediate commands also park here, just for the first boundary.
            WAIT_L: begin
                if (bus.halt_i) begin
                    state_d = DONE;
                end else if (boundary && (immed_q || nxt_word == l_q)) begin
                    tr_d    = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (bus.halt_i) halt_d = 1'b1;
                if (boundary && (halt_q || bus.halt_i || nxt_word == t_q)) begin
                    tr_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= 5'd0;
            word_q  <= 7'd0;
            l_q     <= 7'd0;
            t_q     <= 7'd0;
            immed_q <= 1'b0;
            halt_q  <= 1'b0;
            tr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            l_q     <= l_d;
            t_q     <= t_d;
            immed_q <= immed_d;
            halt_q  <= halt_d;
            tr_q    <= tr_d;
            err_q   <= err_d;
        end
    end

`ifdef G15_TR_STATS_EN
    logic [6:0] ww_q, ww_d;

    always_comb begin
        ww_d = ww_q;
        if (accept) ww_d = 7'd0;
        else if (state_q == WAIT_L && boundary) ww_d = ww_q + 7'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ww_q <= 7'd0;
        else     ww_q <= ww_d;
    end

    assign bus.wait_words_o = ww_q;
`endif

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.cmd_done_o  = (state_q == DONE);
    assign bus.cmd_err_o   = err_q;
    assign bus.tr_o        = tr_q;
    assign bus.t0_o        = (bit_q == 5'd0);
    assign bus.t28_o       = (bit_q == BIT_LAST);
    assign bus.bit_time_o  = bit_q;
    assign bus.word_time_o = word_q;
    assign bus.word_mod4_o = word_q[1:0];
endmodule

// File: tb/tb_transfer_timing.sv
// Bench for transfer_timing: drum position derived from cycles since reset, TR windows computed arithmetically per command.
module tb_transfer_timing;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   total = 0;
    int   bad = 0;

    transfer_timing_if bus();
    transfer_timing dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int word_of(int n); return (n / 29) % 108; endfunction
    function automatic int bit_of(int n);  return n % 29;         endfunction

    // First word start at or after cycle 'from' that opens the window.
    function automatic int first_start(int from, bit immed, int l);
        int n;
        n = ((from + 28) / 29) * 29;
        for (int i = 0; i < 110; i++) begin
            if (immed || word_of(n) == l) return n;
            n += 29;
        end
        return n;
    endfunction

    task automatic goto_pos(input int w, input int b);
        int k = 0;
        while (!(word_of(cyc) == w && bit_of(cyc) == b) && k < 3200) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (bus.word_time_o !== 7'(w) || bus.bit_time_o !== 5'(b)) begin
            bad++;
            $display("FAIL goto: got word=%0d bit=%0d want word=%0d bit=%0d",
                     bus.word_time_o, bus.bit_time_o, w, b);
        end
    endtask

    // Offer one command at the current negedge and check every cycle until READY returns.
    task automatic do_transfer(input bit immed, input int l, input int t, input int halt_at,
                               input bit spam, output int tr_cnt, output int done_cnt);
        int a, s, len, nat_e, e, n, ww_exp, ww_end;
        bit has_tr;
        logic [3:0] exp_v, got_v;
        a = cyc;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_l_i     = 7'(l);
        bus.cmd_t_i     = 7'(t);
        bus.cmd_immed_i = immed;
        s      = first_start(a + 2, immed, l);
        len    = (t - word_of(s) + 108) % 108;
        if (len == 0) len = 108;
        nat_e  = s + 29 * len;
        e      = nat_e;
        has_tr = 1'b1;
        ww_end = s - 1;
        if (halt_at >= 0) begin
            if (halt_at < s) begin
                e      = halt_at + 1;
                has_tr = 1'b0;
                ww_end = halt_at;
            end else if (halt_at < nat_e && ((halt_at + 29) / 29) * 29 < e) begin
                e = ((halt_at + 29) / 29) * 29;
            end
        end
        ww_exp = 0;
        for (int m = a + 1; m <= ww_end; m++) if (m % 29 == 28) ww_exp++;
        tr_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < e - a + 1; k++) begin
            @(negedge clk);
            n = cyc;
            exp_v = {has_tr && n >= s && n < e, n == e, n > e, 1'b0};
            got_v = {bus.tr_o, bus.cmd_done_o, bus.cmd_ready_o, bus.cmd_err_o};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL xfer cyc=%0d (w%0d b%0d): got tr/done/rdy/err=%b want %b",
                         n, word_of(n), bit_of(n), got_v, exp_v);
            end
            tr_cnt   += (bus.tr_o === 1'b1) ? 1 : 0;
            done_cnt += (bus.cmd_done_o === 1'b1) ? 1 : 0;
            bus.halt_i = (n == halt_at);
            if (spam && n > s && n < e - 1) begin
                bus.cmd_valid_i = 1'b1;
                bus.cmd_l_i     = 7'($urandom_range(107));
                bus.cmd_t_i     = 7'($urandom_range(107));
                bus.cmd_immed_i = 1'($urandom_range(1));
            end else begin
                bus.cmd_valid_i = 1'b0;
            end
        end
`ifdef G15_TR_STATS_EN
        total++;
        if (bus.wait_words_o !== 7'(ww_exp)) begin
            bad++;
            $display("FAIL wait_words: got %0d want %0d", bus.wait_words_o, ww_exp);
        end
`endif
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({bus.bit_time_o, bus.word_time_o, bus.tr_o, bus.cmd_done_o, bus.cmd_err_o,
             bus.cmd_ready_o, bus.t0_o, bus.t28_o} !== {5'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset: got bit=%0d word=%0d tr=%b done=%b err=%b rdy=%b t0=%b t28=%b",
                     bus.bit_time_o, bus.word_time_o, bus.tr_o, bus.cmd_done_o, bus.cmd_err_o,
                     bus.cmd_ready_o, bus.t0_o, bus.t28_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_counters;
        logic [15:0] exp_v, got_v;
        for (int k = 0; k < 3200; k++) begin
            exp_v = {5'(bit_of(cyc)), 7'(word_of(cyc)), 2'(word_of(cyc) % 4),
                     bit_of(cyc) == 0, bit_of(cyc) == 28};
            got_v = {bus.bit_time_o, bus.word_time_o, bus.word_mod4_o, bus.t0_o, bus.t28_o};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL counters cyc=%0d: got %h want %h", cyc, got_v, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_deferred;
        int trc, dc;
        goto_pos(2, 0);
        do_transfer(1'b0, 5, 8, -1, 1'b0, trc, dc);
        total++;
        if (trc != 87 || dc != 1) begin
            bad++;
            $display("FAIL deferred: got tr=%0d done=%0d want tr=87 done=1", trc, dc);
        end
    endtask

    task automatic test_immediate;
        int trc, dc;
        goto_pos(7, 12);
        do_transfer(1'b1, 0, 10, -1, 1'b0, trc, dc);
        total++;
        if (trc != 58 || dc != 1) begin
            bad++;
            $display("FAIL immediate: got tr=%0d done=%0d want tr=58 done=1", trc, dc);
        end
    endtask

    task automatic test_full_rev;
        int trc, dc;
        goto_pos(1, 0);
        do_transfer(1'b0, 3, 3, -1, 1'b1, trc, dc);
        total++;
        if (trc != 3132 || dc != 1) begin
            bad++;
            $display("FAIL full_rev: got tr=%0d done=%0d want tr=3132 done=1", trc, dc);
        end
    endtask

    task automatic test_error;
        logic [2:0] got_v;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_l_i     = 7'd110;
        bus.cmd_t_i     = 7'd5;
        bus.cmd_immed_i = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        got_v = {bus.cmd_err_o, bus.cmd_ready_o, bus.tr_o};
        total++;
        if (got_v !== 3'b110) begin
            bad++;
            $display("FAIL err_l: got err/rdy/tr=%b want 110", got_v);
        end
        @(negedge clk);
        got_v = {bus.cmd_err_o, bus.cmd_ready_o, bus.tr_o};
        total++;
        if (got_v !== 3'b010) begin
            bad++;
            $display("FAIL err_pulse: got err/rdy/tr=%b want 010", got_v);
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_l_i     = 7'd4;
        bus.cmd_t_i     = 7'd108;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        got_v = {bus.cmd_err_o, bus.cmd_ready_o, bus.tr_o};
        total++;
        if (got_v !== 3'b110) begin
            bad++;
            $display("FAIL err_t: got err/rdy/tr=%b want 110", got_v);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            got_v = {bus.cmd_err_o, bus.cmd_ready_o, bus.tr_o};
            total++;
            if (got_v !== 3'b010) begin
                bad++;
                $display("FAIL err_idle cyc=%0d: got err/rdy/tr=%b want 010", cyc, got_v);
            end
        end
    endtask

    task automatic test_halt;
        int trc, dc, h;
        goto_pos(10, 0);
        h = cyc + ((20 * 29 + 4) - (cyc % 3132) + 3132) % 3132;
        do_transfer(1'b0, 15, 40, h, 1'b0, trc, dc);
        total++;
        if (trc != 174 || dc != 1) begin
            bad++;
            $display("FAIL halt_xfer: got tr=%0d done=%0d want tr=174 done=1", trc, dc);
        end
        do_transfer(1'b0, (word_of(cyc) + 50) % 108, 7, cyc + 40, 1'b0, trc, dc);
        total++;
        if (trc != 0 || dc != 1) begin
            bad++;
            $display("FAIL halt_wait: got tr=%0d done=%0d want tr=0 done=1", trc, dc);
        end
    endtask

    task automatic test_back_to_back;
        int trc, dc, h;
        for (int i = 0; i < 4; i++) begin
            h = ($urandom_range(1) == 1) ? cyc + int'($urandom_range(2500)) : -1;
            do_transfer(1'($urandom_range(1)), int'($urandom_range(107)),
                        int'($urandom_range(107)), h, 1'b0, trc, dc);
            total++;
            if (dc != 1) begin
                bad++;
                $display("FAIL random %0d: got done=%0d want 1", i, dc);
            end
        end
    endtask

    task automatic test_reset_mid;
        int k = 0;
        logic [2:0] got_v;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_l_i     = 7'd0;
        bus.cmd_t_i     = 7'((word_of(cyc) + 60) % 108);
        bus.cmd_immed_i = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        while (bus.tr_o !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        total++;
        if (bus.tr_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: got tr=%b want 1", bus.tr_o);
        end
        #2 rst = 1'b1;
        #1;
        got_v = {bus.tr_o, bus.cmd_done_o, bus.cmd_ready_o};
        total++;
        if (got_v !== 3'b001) begin
            bad++;
            $display("FAIL rst_mid_async: got tr/done/rdy=%b want 001", got_v);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 120; j++) begin
            got_v = {bus.tr_o, bus.cmd_done_o, bus.cmd_ready_o};
            total++;
            if (got_v !== 3'b001 || bus.bit_time_o !== 5'(bit_of(cyc)) || bus.word_time_o !== 7'(word_of(cyc))) begin
                bad++;
                $display("FAIL rst_mid_after cyc=%0d: got tr/done/rdy=%b bit=%0d word=%0d want 001 bit=%0d word=%0d",
                         cyc, got_v, bus.bit_time_o, bus.word_time_o, bit_of(cyc), word_of(cyc));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_l_i     = 7'd0;
        bus.cmd_t_i     = 7'd0;
        bus.cmd_immed_i = 1'b0;
        bus.halt_i      = 1'b0;
        test_reset;
        test_counters;
        test_deferred;
        test_immediate;
        test_full_rev;
        test_error;
        test_halt;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
